// File: rtl/scan_bus_master_pkg.sv
// scan_bus_master_pkg: shared FSM state type, default sizing and scan frame field offsets
package scan_bus_master_pkg;
  localparam int DEF_ADDR_W  = 11;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TMO_CYC = 15;
  localparam int FRAME_W     = 1 + DEF_ADDR_W + DEF_DATA_W;
  localparam int WR_BIT      = FRAME_W - 1;
  localparam int ADDR_LSB    = DEF_DATA_W;
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;
endpackage

// File: rtl/scan_bus_master.sv
// scan_bus_master: deserialises a {wr, addr, data} scan frame and issues one scan bus transaction
module scan_bus_master
  import scan_bus_master_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TMO_CYC = DEF_TMO_CYC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scan_in,
  input  logic              scan_shift_en,
  input  logic              scan_update,
  output logic              scan_out,
  output logic              txn_busy,
  output logic              txn_timeout,
  output logic              scan_ren,
  output logic              scan_wen,
  output logic [ADDR_W-1:0] scan_addr,
  output logic [DATA_W-1:0] scan_wdata,
  input  logic [DATA_W-1:0] scan_rdata,
  input  logic              scan_ready
);
  localparam int FW = 1 + ADDR_W + DATA_W;
  localparam int CW = $clog2(TMO_CYC + 1);
  state_t              r_state;
  state_t              w_nxt;
  logic [FW-1:0]       r_chain;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_wr;
  logic                r_tmo;
  logic [CW-1:0]       r_cnt;
  logic                w_done;
  logic                w_to;
  logic                w_launch;
  logic                w_shift;
  assign w_launch    = (r_state == ST_IDLE) && scan_update;
  assign w_shift     = (r_state == ST_IDLE) && scan_shift_en && !scan_update;
  assign scan_out    = r_chain[0];
  assign txn_busy    = r_state != ST_IDLE;
  assign txn_timeout = r_tmo;
  assign scan_wen    = (r_state == ST_REQ) && r_wr;
  assign scan_ren    = (r_state == ST_REQ) && !r_wr;
  assign scan_addr   = r_addr;
  assign scan_wdata  = r_wdata;
  always_comb begin
    w_nxt  = r_state;
    w_done = 1'b0;
    w_to   = 1'b0;
    case (r_state)
      ST_IDLE: w_nxt = scan_update ? ST_REQ : ST_IDLE;
      ST_REQ: begin
        w_done = scan_ready;
        w_nxt  = scan_ready ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: begin
        w_to   = !scan_ready && (r_cnt == CW'(TMO_CYC - 1));
        w_done = scan_ready || w_to;
        w_nxt  = w_done ? ST_IDLE : ST_WAIT;
      end
      default: w_nxt = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_chain <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wr    <= 1'b0;
      r_tmo   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= (r_state == ST_WAIT) ? r_cnt + CW'(1) : '0;
      if (w_launch) begin
        r_addr  <= r_chain[FW-2:DATA_W];
        r_wdata <= r_chain[DATA_W-1:0];
        r_wr    <= r_chain[FW-1];
        r_tmo   <= 1'b0;
      end else if (w_done) begin
        r_addr  <= '0;
        r_wdata <= '0;
        r_tmo   <= w_to;
      end
      // read data is captured even on timeout: status sources never raise ready
      if (w_shift) r_chain <= {scan_in, r_chain[FW-1:1]};
      else if (w_done && !r_wr) r_chain[DATA_W-1:0] <= scan_rdata;
    end
  end
endmodule
